// File: rtl/obc_shift_accumulator_if.sv
// Handshake/data bundle between the OBC coefficient ROM pair, this
// shift-accumulate stage and the consumer of the partial-product sums.
interface obc_shift_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int NBITS  = 16
);
  localparam int ACC_W = DATA_W + NBITS + 1;

  logic              start;
  logic [DATA_W-1:0] offset_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rom0;
  logic [DATA_W-1:0] rom1;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              busy;

  modport master (
    output start, offset_in, in_valid, rom0, rom1, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, offset_in, in_valid, rom0, rom1, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/obc_shift_accumulator.sv
// Bit-serial shift-accumulate stage of the OBC DA DFT datapath. The offset
// preloads the accumulator, each bit-plane's ROM word pair is added at weight
// 2^plane, and the top (sign) plane is subtracted. One signed sum per NBITS
// accepted planes, held in DONE until the consumer takes it.
module obc_shift_accumulator #(
  parameter int DATA_W = 32,
  parameter int NBITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  obc_shift_accumulator_if.slave bus
);
  localparam int ACC_W = DATA_W + NBITS + 1;
  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt, result_q;
  logic [CNT_W-1:0]  cnt;
  logic              beat, last;
  logic [DATA_W:0]   term;
  logic [ACC_W-1:0]  term_ext, addend;

  assign beat = bus.in_valid && (state == ACCUM);
  assign last = (cnt == LAST);

  // Plane term: word pair summed one bit wider so it cannot wrap, then
  // weighted by 2^cnt; the sign plane carries negative weight.
  always_comb begin
    term     = {bus.rom0[DATA_W-1], bus.rom0} + {bus.rom1[DATA_W-1], bus.rom1};
    term_ext = {{(ACC_W-DATA_W-1){term[DATA_W]}}, term};
    addend   = term_ext << cnt;
    acc_nxt  = last ? (acc - addend) : (acc + addend);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start only matters in IDLE, no abort path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)    state_nxt = ACCUM;
      ACCUM:   if (beat && last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, plane counter and result register; result only updates on
  // the sign-plane beat so it stays stable through DONE and the next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (state == IDLE && bus.start) begin
      acc <= {{(ACC_W-DATA_W){bus.offset_in[DATA_W-1]}}, bus.offset_in};
      cnt <= '0;
    end else if (beat) begin
      acc <= acc_nxt;
      if (last) result_q <= acc_nxt;
      else      cnt      <= cnt + CNT_W'(1);
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.result = result_q;
endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Directed bench for obc_shift_accumulator: a reference model pushes the
// expected sum when a run starts; the value is popped when out_valid rises.
module tb_obc_shift_accumulator;
  localparam int DATA_W = 32;
  localparam int NBITS  = 16;
  localparam int ACC_W  = DATA_W + NBITS + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obc_shift_accumulator_if #(.DATA_W(DATA_W), .NBITS(NBITS)) bus ();
  obc_shift_accumulator #(.DATA_W(DATA_W), .NBITS(NBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0]  sb[$];
  logic [DATA_W-1:0] w0[NBITS];
  logic [DATA_W-1:0] w1[NBITS];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [ACC_W-1:0] sx(input longint v);
    return v[ACC_W-1:0];
  endfunction

  // Reference: offset + sum_{i<N-1} t_i*2^i - t_{N-1}*2^(N-1), in 64-bit.
  function automatic logic [ACC_W-1:0] model(input logic [DATA_W-1:0] off);
    longint acc, t;
    acc = longint'($signed(off));
    for (int i = 0; i < NBITS; i++) begin
      t = longint'($signed(w0[i])) + longint'($signed(w1[i]));
      if (i == NBITS-1) acc = acc - t * (longint'(1) << i);
      else              acc = acc + t * (longint'(1) << i);
    end
    return acc[ACC_W-1:0];
  endfunction

  function automatic void fill(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    for (int i = 0; i < NBITS; i++) begin
      w0[i] = a;
      w1[i] = b;
    end
  endfunction

  // One full run: start, feed NBITS planes (optionally with gaps), collect
  // the result, optionally hold it in DONE for `hold` cycles, return to IDLE.
  task automatic run(input logic [DATA_W-1:0] off, input bit gap, input int hold, input string tag);
    int lat, beats;
    bit ph;
    logic [ACC_W-1:0] expv, held;
    sb.push_back(model(off));
    bus.offset_in = off;
    bus.start     = 1'b1;
    bus.in_valid  = 1'b1;          // ignored while still in IDLE
    bus.rom0      = w0[0];
    bus.rom1      = w1[0];
    bus.out_ready = (hold == 0);
    beats = 0; ph = 1'b0;
    step;                          // start accepted on this edge
    lat = 1;
    bus.start = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      bus.in_valid = gap ? ph : 1'b1;
      ph = ~ph;
      bus.rom0 = w0[beats % NBITS];
      bus.rom1 = w1[beats % NBITS];
      if (bus.in_valid && bus.in_ready) beats++;
      step;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " out_valid"}, ACC_W'(bus.out_valid), ACC_W'(1));
    if (!gap) chk({tag, " latency"}, ACC_W'(lat), ACC_W'(NBITS + 1));
    chk({tag, " beats"}, ACC_W'(beats), ACC_W'(NBITS));
    expv = sb.pop_front();
    chk({tag, " result"}, bus.result, expv);
    held = bus.result;
    for (int h = 0; h < hold; h++) begin
      bus.start    = h[0];
      bus.in_valid = ~h[0];
      step;
      chk({tag, " hold result"}, bus.result, held);
      chk({tag, " hold out_valid"}, ACC_W'(bus.out_valid), ACC_W'(1));
      chk({tag, " hold in_ready"}, ACC_W'(bus.in_ready), ACC_W'(0));
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step;
    chk({tag, " idle out_valid"}, ACC_W'(bus.out_valid), ACC_W'(0));
    chk({tag, " idle busy"}, ACC_W'(bus.busy), ACC_W'(0));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.offset_in = '0; bus.in_valid = 1'b0;
    bus.rom0 = '0; bus.rom1 = '0; bus.out_ready = 1'b1;
    step; step;
    chk("reset in_ready", ACC_W'(bus.in_ready), ACC_W'(0));
    chk("reset out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
    chk("reset busy", ACC_W'(bus.busy), ACC_W'(0));
    chk("reset result", bus.result, '0);
    rst = 1'b0;
    step;

    // Sign-plane weighting: 2^20*(2^15-1) - 2^20*2^15 = -2^20.
    fill(32'h0010_0000, 32'h0);
    run(32'h0, 1'b0, 0, "signplane");
    chk("signplane const", bus.result, sx(-64'sd1048576));

    // Cancelling pair leaves only the offset; back-to-back start from IDLE.
    fill(32'hFFF0_0000, 32'h0010_0000);
    run(32'h0000_0123, 1'b0, 0, "cancel");
    chk("cancel const", bus.result, sx(64'sh123));

    // Input back-pressure: same answer as the gap-free run.
    fill(32'h0010_0000, 32'h0);
    run(32'h0, 1'b1, 0, "gap");
    chk("gap const", bus.result, sx(-64'sd1048576));

    // Output back-pressure with varied plane words.
    for (int i = 0; i < NBITS; i++) begin
      w0[i] = $urandom;
      w1[i] = $urandom;
    end
    run($urandom, 1'b0, 10, "holdrand");

    // Extreme words: every plane at the most negative pair.
    fill(32'h8000_0000, 32'h8000_0000);
    run(32'h7FFF_FFFF, 1'b0, 0, "extreme");

    // Reset mid-run after 7 accepted beats.
    fill(32'hFFF0_0000, 32'h0010_0000);
    bus.offset_in = 32'h0000_0123;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.rom0 = w0[0];
    bus.rom1 = w1[0];
    step;
    bus.start = 1'b0;
    repeat (7) step;
    #2 rst = 1'b1;
    #1;
    chk("midrst in_ready", ACC_W'(bus.in_ready), ACC_W'(0));
    chk("midrst out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
    chk("midrst busy", ACC_W'(bus.busy), ACC_W'(0));
    chk("midrst result", bus.result, '0);
    bus.in_valid = 1'b0;
    step;
    rst = 1'b0;
    step;
    run(32'h0000_0123, 1'b0, 0, "postrst");
    chk("postrst const", bus.result, sx(64'sh123));

    // Most negative offset with zero ROM words.
    fill(32'h0, 32'h0);
    run(32'h8000_0000, 1'b0, 0, "negoff");
    chk("negoff const", bus.result, sx(-64'sd2147483648));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
